controller_sequencer: RTL and testbench
=======================================

Name: controller_sequencer

Overview:
- Moore-style microsequencer that drives every control input of the 8-bit bus datapath (PC, MAR, RAM, MDR, A/B/C/temp, ALU, IR, output and input buffers).
- Fetches an opcode byte and an optional operand/address byte from RAM through MAR/MDR, decodes the IR, and runs per-instruction execute states.
- Keeps its own latched zero/carry flags for conditional jumps and stops in HALT on the HLT opcode.

Parameters:
- RAM_RD_WAIT, 1, number of ce_ram-only wait cycles between MAR load and MDR capture (0..3).
- HLT_OPCODE, 8'hFF, opcode that enters HALT.

Ports:
- clk  in  1  system clock, rising edge
- clear  in  1  asynchronous, active-low reset
- controller_sequencer_input  in  8  IR contents (opcode)
- zero_flag  in  1  combinational ALU zero flag
- carry_flag  in  1  combinational ALU carry flag
- count_pc, load_pc, enable_pc  out  1 each  PC increment / load from bus / drive bus
- load_mar  out  1  MAR load from bus
- ce_ram, we_ram  out  1 each  RAM chip enable / write enable
- flip_flop  out  1  MDR input select: 0 = RAM, 1 = bus
- load_mdr_reg, enable_mdr_reg  out  1 each
- load_accum, enable_accum, load_b_reg, enable_b_reg, load_c_reg, enable_c_reg  out  1 each
- load_temp_reg, sub_mode, enable_alu, load_output_reg, enable_input  out  1 each
- load_inst_reg, clear_inst_reg  out  1 each
- halted  out  1  high in HALT
- z_latched, c_latched  out  1 each  flag register contents

Behaviour:
- Reset (clear=0, asynchronous): state=INIT, z/c latches=0, wait counter=0. Every output is 0 except clear_inst_reg=1 while in INIT. INIT->F_ADDR unconditionally on the first edge after release.
- Outputs are decoded from state, latched opcode and latches only. No input-to-output combinational path except through state.
- Bus rule: at most one of enable_pc/accum/b/c/alu/mdr/input is high in any state. The bench checks this every cycle.
- Read macro RD(x): x_ADDR (source->bus, load_mar), then RAM_RD_WAIT states x_WAIT (ce_ram), then x_CAP (ce_ram, flip_flop=0, load_mdr_reg). With RAM_RD_WAIT=0, x_CAP immediately follows x_ADDR.
- Fetch: RD(F) with source PC (enable_pc). count_pc is asserted in the last state before F_CAP. F_IR: enable_mdr_reg, load_inst_reg. DECODE: no outputs; next state is chosen from the opcode.
- Operand fetch (opcodes 01,02,0D,0E,0F): RD(O) with source PC, count_pc as in fetch. Operand ends in MDR.
- Opcodes and execute states:
  - 00 NOP: no execute states.
  - 01 LDA a: M_ADDR (enable_mdr_reg, load_mar), M_WAIT, M_CAP (RD timing), X_LDA (enable_mdr_reg, load_accum).
  - 02 STA a: M_ADDR, then X_ST1 (enable_accum, flip_flop=1, load_mdr_reg), then X_ST2 (ce_ram, we_ram).
  - 03/04 ADD/SUB B and 05/06 ADD/SUB C: X_T (enable_b_reg or enable_c_reg, load_temp_reg), then X_ALU (enable_alu, load_accum, sub_mode=1 for 04/06). On the X_ALU edge, z_latched<=zero_flag and c_latched<=carry_flag.
  - 07 MOV B,A / 08 MOV C,A: enable_accum with load_b_reg or load_c_reg.
  - 09 MOV A,B / 0A MOV A,C: enable_b_reg or enable_c_reg with load_accum.
  - 0B IN: enable_input, load_accum.
  - 0C OUT: enable_accum, load_output_reg.
  - 0D JMP a: X_J (enable_mdr_reg, load_pc).
  - 0E JZ a / 0F JC a: X_J if z_latched or c_latched is 1; otherwise straight to F_ADDR (PC already points past the operand).
  - HLT_OPCODE: HALT. All other opcodes execute as NOP.
- Every execute path returns to F_ADDR after its last state.
- HALT: halted=1, all other outputs 0. Exits only on reset.
- Cycle counts with RAM_RD_WAIT=1:
  - fetch+decode: 5
  - NOP: 5
  - MOV/IN/OUT: 6
  - ADD/SUB: 7
  - JMP/JZ-taken: 9
  - JZ-not-taken: 8
  - STA: 11
  - LDA: 12
- Flags change only in X_ALU. Counters and PC wrap modulo 256 (datapath behaviour); the controller does not check for wrap.
- Reset mid-instruction: INIT is entered immediately. A half-done STA must not leave we_ram asserted after clear falls.

Test Plan:
- Reset released → INIT for 1 cycle with clear_inst_reg=1, then F_ADDR with enable_pc=1 and load_mar=1. All other outputs are 0 during reset.
- Program LDA 0x10; ADD B; OUT; HLT, with M[0x10]=0x05 and B=0x03 → output register=0x08, halted=1 after 12+7+6+5 cycles, z_latched=0, c_latched=0.
- LDA 0xFF-valued byte; MOV B,A; ADD B → A=0xFE, c_latched=1. Then JC 0x20 → PC=0x20 on the X_J edge.
- SUB B with A=B=0x07 → A=0x00, z_latched=1. JZ taken in 9 cycles. Repeat with z=0 → not taken in 8 cycles, PC=operand address+1.
- STA 0x30 with A=0xA5 → exactly one cycle with ce_ram=we_ram=1, flip_flop=1 on the preceding MDR load, M[0x30]=0xA5.
- Assert clear during X_ST2 and during X_ALU → outputs drop to 0 asynchronously and latches clear. Run with RAM_RD_WAIT=0 and 3 → cycle counts shift by the wait count per read. Undefined opcode 0x42 → NOP timing.

Source files
------------

// File: rtl/controller_sequencer.sv
// Moore microsequencer for the 8-bit bus datapath: fetch, optional operand/address
// reads through MAR/MDR, per-opcode execute states, latched Z/C flags and HALT.
module controller_sequencer #(
    parameter int          RAM_RD_WAIT = 1,
    parameter logic [7:0]  HLT_OPCODE  = 8'hFF
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [7:0] controller_sequencer_input,
    input  logic       zero_flag,
    input  logic       carry_flag,
    output logic       count_pc,
    output logic       load_pc,
    output logic       enable_pc,
    output logic       load_mar,
    output logic       ce_ram,
    output logic       we_ram,
    output logic       flip_flop,
    output logic       load_mdr_reg,
    output logic       enable_mdr_reg,
    output logic       load_accum,
    output logic       enable_accum,
    output logic       load_b_reg,
    output logic       enable_b_reg,
    output logic       load_c_reg,
    output logic       enable_c_reg,
    output logic       load_temp_reg,
    output logic       sub_mode,
    output logic       enable_alu,
    output logic       load_output_reg,
    output logic       enable_input,
    output logic       load_inst_reg,
    output logic       clear_inst_reg,
    output logic       halted,
    output logic       z_latched,
    output logic       c_latched
);

    typedef enum logic [4:0] {
        S_INIT, S_F_ADDR, S_F_WAIT, S_F_CAP, S_F_IR, S_DECODE,
        S_O_ADDR, S_O_WAIT, S_O_CAP, S_M_ADDR, S_M_WAIT, S_M_CAP,
        S_X_LDA, S_X_ST1, S_X_ST2, S_X_T, S_X_ALU, S_X_MOV, S_X_J, S_HALT
    } state_t;

    localparam bit         NO_WAIT   = (RAM_RD_WAIT == 0);
    localparam logic [1:0] WAIT_LAST = 2'((RAM_RD_WAIT > 0) ? (RAM_RD_WAIT - 1) : 0);

    state_t     r_state, w_next_state;
    logic [1:0] r_wait_cnt, w_wait_next;
    logic [7:0] r_opcode, w_opcode_next;
    logic       r_z_latched, r_c_latched;
    logic       w_wait_last;

    assign w_wait_last = (r_wait_cnt == WAIT_LAST);
    assign z_latched   = r_z_latched;
    assign c_latched   = r_c_latched;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state     <= S_INIT;
            r_wait_cnt  <= 2'd0;
            r_opcode    <= 8'h00;
            r_z_latched <= 1'b0;
            r_c_latched <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_next;
            r_opcode   <= w_opcode_next;
            if (r_state == S_X_ALU) begin
                r_z_latched <= zero_flag;
                r_c_latched <= carry_flag;
            end
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_wait_next     = r_wait_cnt;
        w_opcode_next   = r_opcode;
        count_pc        = 1'b0;  load_pc        = 1'b0;  enable_pc       = 1'b0;
        load_mar        = 1'b0;  ce_ram         = 1'b0;  we_ram          = 1'b0;
        flip_flop       = 1'b0;  load_mdr_reg   = 1'b0;  enable_mdr_reg  = 1'b0;
        load_accum      = 1'b0;  enable_accum   = 1'b0;  load_b_reg      = 1'b0;
        enable_b_reg    = 1'b0;  load_c_reg     = 1'b0;  enable_c_reg    = 1'b0;
        load_temp_reg   = 1'b0;  sub_mode       = 1'b0;  enable_alu      = 1'b0;
        load_output_reg = 1'b0;  enable_input   = 1'b0;  load_inst_reg   = 1'b0;
        clear_inst_reg  = 1'b0;  halted         = 1'b0;

        case (r_state)
            S_INIT: begin
                clear_inst_reg = 1'b1;
                w_next_state   = S_F_ADDR;
            end
            // PC increments in the last state before the capture, whichever that is
            S_F_ADDR, S_O_ADDR: begin
                enable_pc   = 1'b1;
                load_mar    = 1'b1;
                count_pc    = NO_WAIT;
                w_wait_next = 2'd0;
                if (r_state == S_F_ADDR) w_next_state = NO_WAIT ? S_F_CAP : S_F_WAIT;
                else                     w_next_state = NO_WAIT ? S_O_CAP : S_O_WAIT;
            end
            S_F_WAIT, S_O_WAIT, S_M_WAIT: begin
                ce_ram   = 1'b1;
                count_pc = w_wait_last && (r_state != S_M_WAIT);
                if (w_wait_last) begin
                    w_wait_next = 2'd0;
                    case (r_state)
                        S_F_WAIT: w_next_state = S_F_CAP;
                        S_O_WAIT: w_next_state = S_O_CAP;
                        default:  w_next_state = S_M_CAP;
                    endcase
                end else begin
                    w_wait_next = r_wait_cnt + 2'd1;
                end
            end
            S_F_CAP, S_O_CAP, S_M_CAP: begin
                ce_ram       = 1'b1;
                load_mdr_reg = 1'b1;
                if (r_state == S_F_CAP) begin
                    w_next_state = S_F_IR;
                end else if (r_state == S_M_CAP) begin
                    w_next_state = S_X_LDA;
                end else begin
                    case (r_opcode)
                        8'h01, 8'h02: w_next_state = S_M_ADDR;
                        8'h0D:        w_next_state = S_X_J;
                        8'h0E:        w_next_state = r_z_latched ? S_X_J : S_F_ADDR;
                        8'h0F:        w_next_state = r_c_latched ? S_X_J : S_F_ADDR;
                        default:      w_next_state = S_F_ADDR;
                    endcase
                end
            end
            S_F_IR: begin
                enable_mdr_reg = 1'b1;
                load_inst_reg  = 1'b1;
                w_next_state   = S_DECODE;
            end
            S_DECODE: begin
                w_opcode_next = controller_sequencer_input;
                if (controller_sequencer_input == HLT_OPCODE) begin
                    w_next_state = S_HALT;
                end else begin
                    case (controller_sequencer_input)
                        8'h01, 8'h02, 8'h0D, 8'h0E, 8'h0F:               w_next_state = S_O_ADDR;
                        8'h03, 8'h04, 8'h05, 8'h06:                      w_next_state = S_X_T;
                        8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C:        w_next_state = S_X_MOV;
                        default:                                         w_next_state = S_F_ADDR;
                    endcase
                end
            end
            S_M_ADDR: begin
                enable_mdr_reg = 1'b1;
                load_mar       = 1'b1;
                w_wait_next    = 2'd0;
                if (r_opcode == 8'h02) w_next_state = S_X_ST1;
                else                   w_next_state = NO_WAIT ? S_M_CAP : S_M_WAIT;
            end
            S_X_LDA: begin
                enable_mdr_reg = 1'b1;
                load_accum     = 1'b1;
                w_next_state   = S_F_ADDR;
            end
            S_X_ST1: begin
                enable_accum = 1'b1;
                flip_flop    = 1'b1;
                load_mdr_reg = 1'b1;
                w_next_state = S_X_ST2;
            end
            S_X_ST2: begin
                ce_ram       = 1'b1;
                we_ram       = 1'b1;
                w_next_state = S_F_ADDR;
            end
            S_X_T: begin
                enable_b_reg  = (r_opcode == 8'h03) || (r_opcode == 8'h04);
                enable_c_reg  = (r_opcode == 8'h05) || (r_opcode == 8'h06);
                load_temp_reg = 1'b1;
                w_next_state  = S_X_ALU;
            end
            S_X_ALU: begin
                enable_alu   = 1'b1;
                load_accum   = 1'b1;
                sub_mode     = (r_opcode == 8'h04) || (r_opcode == 8'h06);
                w_next_state = S_F_ADDR;
            end
            S_X_MOV: begin
                enable_accum    = (r_opcode == 8'h07) || (r_opcode == 8'h08) || (r_opcode == 8'h0C);
                enable_b_reg    = (r_opcode == 8'h09);
                enable_c_reg    = (r_opcode == 8'h0A);
                enable_input    = (r_opcode == 8'h0B);
                load_b_reg      = (r_opcode == 8'h07);
                load_c_reg      = (r_opcode == 8'h08);
                load_accum      = (r_opcode == 8'h09) || (r_opcode == 8'h0A) || (r_opcode == 8'h0B);
                load_output_reg = (r_opcode == 8'h0C);
                w_next_state    = S_F_ADDR;
            end
            S_X_J: begin
                enable_mdr_reg = 1'b1;
                load_pc        = 1'b1;
                w_next_state   = S_F_ADDR;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next_state = S_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_controller_sequencer.sv
// Bench: three sequencers (read waits 1, 0, 3) each driving a behavioural bus datapath;
// OUT, RAM-write and PC-load events are checked against a queue of expected events.
module tb_controller_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] clear_n;
    logic [2:0] count_pc, load_pc, enable_pc, load_mar, ce_ram, we_ram, flip_flop;
    logic [2:0] load_mdr_reg, enable_mdr_reg, load_accum, enable_accum, load_b_reg, enable_b_reg;
    logic [2:0] load_c_reg, enable_c_reg, load_temp_reg, sub_mode, enable_alu, load_output_reg;
    logic [2:0] enable_input, load_inst_reg, clear_inst_reg, halted, z_latched, c_latched, zf, cf;

    logic [7:0] pc [3], mar [3], mdr [3], ra [3], rb [3], rc [3], tmp [3], outr [3], ir [3];
    logic [7:0] bus [3], alu [3], init_a [3], init_b [3], init_c [3];
    logic [8:0] sum9 [3];
    logic [7:0] mem [3][256];
    logic [7:0] img [3][256];

    typedef struct packed {
        logic [1:0] kind;   // 0 = OUT, 1 = RAM write, 2 = PC load
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;
    ev_t sb_q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [22:0] O_INIT  = 23'h000002;
    localparam logic [22:0] O_FADDR = 23'h180000;
    localparam logic [22:0] O_FWAIT = 23'h440000;
    localparam logic [22:0] O_HALT  = 23'h000001;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        controller_sequencer #(
            .RAM_RD_WAIT ((gi == 0) ? 1 : ((gi == 1) ? 0 : 3)),
            .HLT_OPCODE  (8'hFF)
        ) u_dut (
            .clk                        (clk),
            .clear                      (clear_n[gi]),
            .controller_sequencer_input (ir[gi]),
            .zero_flag                  (zf[gi]),
            .carry_flag                 (cf[gi]),
            .count_pc                   (count_pc[gi]),
            .load_pc                    (load_pc[gi]),
            .enable_pc                  (enable_pc[gi]),
            .load_mar                   (load_mar[gi]),
            .ce_ram                     (ce_ram[gi]),
            .we_ram                     (we_ram[gi]),
            .flip_flop                  (flip_flop[gi]),
            .load_mdr_reg               (load_mdr_reg[gi]),
            .enable_mdr_reg             (enable_mdr_reg[gi]),
            .load_accum                 (load_accum[gi]),
            .enable_accum               (enable_accum[gi]),
            .load_b_reg                 (load_b_reg[gi]),
            .enable_b_reg               (enable_b_reg[gi]),
            .load_c_reg                 (load_c_reg[gi]),
            .enable_c_reg               (enable_c_reg[gi]),
            .load_temp_reg              (load_temp_reg[gi]),
            .sub_mode                   (sub_mode[gi]),
            .enable_alu                 (enable_alu[gi]),
            .load_output_reg            (load_output_reg[gi]),
            .enable_input               (enable_input[gi]),
            .load_inst_reg              (load_inst_reg[gi]),
            .clear_inst_reg             (clear_inst_reg[gi]),
            .halted                     (halted[gi]),
            .z_latched                  (z_latched[gi]),
            .c_latched                  (c_latched[gi])
        );
    end

    // Datapath model: bus mux and ALU
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            bus[k] = 8'h00;
            if      (enable_pc[k])      bus[k] = pc[k];
            else if (enable_accum[k])   bus[k] = ra[k];
            else if (enable_b_reg[k])   bus[k] = rb[k];
            else if (enable_c_reg[k])   bus[k] = rc[k];
            else if (enable_alu[k])     bus[k] = alu[k];
            else if (enable_mdr_reg[k]) bus[k] = mdr[k];
            else if (enable_input[k])   bus[k] = 8'h3C;
            sum9[k] = sub_mode[k] ? ({1'b0, ra[k]} - {1'b0, tmp[k]}) : ({1'b0, ra[k]} + {1'b0, tmp[k]});
            alu[k]  = sum9[k][7:0];
            cf[k]   = sum9[k][8];
            zf[k]   = (sum9[k][7:0] == 8'h00);
        end
    end

    // Datapath registers; while an instance is held in reset its RAM is reloaded from img
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!clear_n[k]) begin
                pc[k] <= 8'h00; mar[k] <= 8'h00; mdr[k] <= 8'h00; tmp[k] <= 8'h00;
                outr[k] <= 8'h00; ir[k] <= 8'h00;
                ra[k] <= init_a[k]; rb[k] <= init_b[k]; rc[k] <= init_c[k];
                for (int a = 0; a < 256; a++) mem[k][a] <= img[k][a];
            end else begin
                if (load_pc[k])            pc[k] <= bus[k];
                else if (count_pc[k])      pc[k] <= pc[k] + 8'd1;
                if (load_mar[k])           mar[k] <= bus[k];
                if (load_mdr_reg[k])       mdr[k] <= flip_flop[k] ? bus[k] : mem[k][mar[k]];
                if (ce_ram[k] && we_ram[k]) mem[k][mar[k]] <= mdr[k];
                if (load_accum[k])         ra[k] <= bus[k];
                if (load_b_reg[k])         rb[k] <= bus[k];
                if (load_c_reg[k])         rc[k] <= bus[k];
                if (load_temp_reg[k])      tmp[k] <= bus[k];
                if (load_output_reg[k])    outr[k] <= bus[k];
                if (clear_inst_reg[k])     ir[k] <= 8'h00;
                else if (load_inst_reg[k]) ir[k] <= bus[k];
            end
        end
    end

    // Monitor: bus-driver rule every cycle, and event scoreboard
    always @(negedge clk) begin
        int   n;
        logic fire;
        ev_t  obs, exp_ev;
        for (int k = 0; k < 3; k++) begin
            n = $countones({enable_pc[k], enable_accum[k], enable_b_reg[k], enable_c_reg[k],
                            enable_alu[k], enable_mdr_reg[k], enable_input[k]});
            tests_run++;
            if (n > 1) begin
                tests_failed++;
                $display("FAIL bus_rule inst%0d: %0d bus drivers, required at most 1", k, n);
            end
            for (int e = 0; e < 3; e++) begin
                fire = (e == 0) ? load_output_reg[k] : ((e == 1) ? (ce_ram[k] & we_ram[k]) : load_pc[k]);
                if (fire) begin
                    obs.kind = 2'(e);
                    obs.addr = (e == 1) ? mar[k] : 8'h00;
                    obs.data = (e == 1) ? mdr[k] : bus[k];
                    tests_run++;
                    if (sb_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL event inst%0d: got kind %0d addr %02h data %02h, required no event",
                                 k, obs.kind, obs.addr, obs.data);
                    end else begin
                        exp_ev = sb_q.pop_front();
                        if (obs !== exp_ev) begin
                            tests_failed++;
                            $display("FAIL event inst%0d: got kind %0d addr %02h data %02h, required kind %0d addr %02h data %02h",
                                     k, obs.kind, obs.addr, obs.data, exp_ev.kind, exp_ev.addr, exp_ev.data);
                        end
                    end
                end
            end
        end
    end

    function automatic logic [22:0] outs(input int k);
        return {count_pc[k], load_pc[k], enable_pc[k], load_mar[k], ce_ram[k], we_ram[k],
                flip_flop[k], load_mdr_reg[k], enable_mdr_reg[k], load_accum[k], enable_accum[k],
                load_b_reg[k], enable_b_reg[k], load_c_reg[k], enable_c_reg[k], load_temp_reg[k],
                sub_mode[k], enable_alu[k], load_output_reg[k], enable_input[k], load_inst_reg[k],
                clear_inst_reg[k], halted[k]};
    endfunction

    task automatic prep();
        clear_n = 3'b000;
        sb_q.delete();
        for (int k = 0; k < 3; k++) begin
            init_a[k] = 8'h00; init_b[k] = 8'h00; init_c[k] = 8'h00;
            for (int a = 0; a < 256; a++) img[k][a] = 8'h00;
        end
    endtask

    task automatic release_inst(input int k);
        clear_n = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        clear_n[k] = 1'b1;
    endtask

    task automatic run_prog(input int k, input int budget, output int cyc, output int wes);
        bit done;
        cyc = 0; wes = 0; done = 0;
        release_inst(k);
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk); #1;
            if (halted[k]) done = 1;
            else begin
                if (!clear_inst_reg[k]) cyc++;
                if (we_ram[k]) wes++;
            end
        end
        tests_run++;
        if (!done) begin tests_failed++; $display("FAIL halt_timeout inst%0d: got running, required halted within %0d", k, budget); end
    endtask

    task automatic test_reset();
        prep();
        repeat (2) @(negedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (outs(k) !== O_INIT || z_latched[k] !== 1'b0 || c_latched[k] !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_outs inst%0d: got %06h z%0b c%0b, required %06h z0 c0", k, outs(k), z_latched[k], c_latched[k], O_INIT);
            end
        end
        clear_n[0] = 1'b1; #1;
        tests_run++;
        if (outs(0) !== O_INIT) begin tests_failed++; $display("FAIL init_state: got %06h, required %06h", outs(0), O_INIT); end
        @(negedge clk); #1;
        tests_run++;
        if (outs(0) !== O_FADDR) begin tests_failed++; $display("FAIL f_addr: got %06h, required %06h", outs(0), O_FADDR); end
        @(negedge clk); #1;
        tests_run++;
        if (outs(0) !== O_FWAIT) begin tests_failed++; $display("FAIL f_wait: got %06h, required %06h", outs(0), O_FWAIT); end
    endtask

    // LDA 0x10; ADD B; OUT; HLT on each wait setting
    task automatic test_program();
        int cyc, wes;
        int exp_cyc;
        for (int k = 0; k < 3; k++) begin
            prep();
            img[k][0] = 8'h01; img[k][1] = 8'h10; img[k][2] = 8'h03; img[k][3] = 8'h0C; img[k][4] = 8'hFF;
            img[k][8'h10] = 8'h05;
            init_b[k] = 8'h03;
            exp_cyc = (k == 0) ? 30 : ((k == 1) ? 24 : 42);
            sb_q.push_back(ev_t'{kind: 2'd0, addr: 8'h00, data: 8'h08});
            run_prog(k, 200, cyc, wes);
            tests_run++;
            if (cyc !== exp_cyc) begin tests_failed++; $display("FAIL prog_cycles inst%0d: got %0d, required %0d", k, cyc, exp_cyc); end
            tests_run++;
            if (outr[k] !== 8'h08 || ra[k] !== 8'h08) begin tests_failed++; $display("FAIL prog_result inst%0d: got out %02h a %02h, required 08 08", k, outr[k], ra[k]); end
            tests_run++;
            if ({z_latched[k], c_latched[k]} !== 2'b00) begin tests_failed++; $display("FAIL prog_flags inst%0d: got z%0b c%0b, required z0 c0", k, z_latched[k], c_latched[k]); end
            tests_run++;
            if (outs(k) !== O_HALT) begin tests_failed++; $display("FAIL halt_outs inst%0d: got %06h, required %06h", k, outs(k), O_HALT); end
            tests_run++;
            if (sb_q.size() != 0) begin tests_failed++; $display("FAIL prog_events inst%0d: got %0d pending, required 0", k, sb_q.size()); end
        end
    endtask

    // LDA (0xFF); MOV B,A; ADD B -> carry; JC 0x20; HLT at 0x20
    task automatic test_carry_jump();
        int cyc, wes;
        prep();
        img[0][0] = 8'h01; img[0][1] = 8'h40; img[0][2] = 8'h07; img[0][3] = 8'h03;
        img[0][4] = 8'h0F; img[0][5] = 8'h20; img[0][8'h20] = 8'hFF; img[0][8'h40] = 8'hFF;
        sb_q.push_back(ev_t'{kind: 2'd2, addr: 8'h00, data: 8'h20});
        run_prog(0, 200, cyc, wes);
        tests_run++;
        if (cyc !== 39) begin tests_failed++; $display("FAIL jc_cycles: got %0d, required 39", cyc); end
        tests_run++;
        if (ra[0] !== 8'hFE || c_latched[0] !== 1'b1 || z_latched[0] !== 1'b0) begin
            tests_failed++; $display("FAIL jc_alu: got a %02h c%0b z%0b, required a fe c1 z0", ra[0], c_latched[0], z_latched[0]);
        end
        tests_run++;
        if (pc[0] !== 8'h21) begin tests_failed++; $display("FAIL jc_pc: got %02h, required 21", pc[0]); end
        tests_run++;
        if (sb_q.size() != 0) begin tests_failed++; $display("FAIL jc_events: got %0d pending, required 0", sb_q.size()); end
    endtask

    // SUB B (A=B=7) -> Z; JZ taken to 0x08; ADD B -> no Z; JZ not taken; HLT
    task automatic test_zero_jumps();
        int cyc, wes;
        prep();
        init_a[0] = 8'h07; init_b[0] = 8'h07;
        img[0][0] = 8'h04; img[0][1] = 8'h0E; img[0][2] = 8'h08;
        img[0][8] = 8'h03; img[0][9] = 8'h0E; img[0][10] = 8'h30; img[0][11] = 8'hFF;
        sb_q.push_back(ev_t'{kind: 2'd2, addr: 8'h00, data: 8'h08});
        run_prog(0, 200, cyc, wes);
        tests_run++;
        if (cyc !== 36) begin tests_failed++; $display("FAIL jz_cycles: got %0d, required 36", cyc); end
        tests_run++;
        if (ra[0] !== 8'h07 || z_latched[0] !== 1'b0) begin tests_failed++; $display("FAIL jz_state: got a %02h z%0b, required a 07 z0", ra[0], z_latched[0]); end
        tests_run++;
        if (pc[0] !== 8'h0C) begin tests_failed++; $display("FAIL jz_pc: got %02h, required 0c", pc[0]); end
        tests_run++;
        if (sb_q.size() != 0) begin tests_failed++; $display("FAIL jz_events: got %0d pending, required 0", sb_q.size()); end
    endtask

    task automatic test_store();
        int cyc, wes;
        prep();
        init_a[0] = 8'hA5;
        img[0][0] = 8'h02; img[0][1] = 8'h30; img[0][2] = 8'hFF;
        sb_q.push_back(ev_t'{kind: 2'd1, addr: 8'h30, data: 8'hA5});
        run_prog(0, 200, cyc, wes);
        tests_run++;
        if (cyc !== 16 || wes !== 1) begin tests_failed++; $display("FAIL sta_timing: got %0d cycles %0d writes, required 16 cycles 1 write", cyc, wes); end
        tests_run++;
        if (mem[0][8'h30] !== 8'hA5) begin tests_failed++; $display("FAIL sta_mem: got %02h, required a5", mem[0][8'h30]); end
        tests_run++;
        if (sb_q.size() != 0) begin tests_failed++; $display("FAIL sta_events: got %0d pending, required 0", sb_q.size()); end
    endtask

    // Undefined opcode 0x42 and NOP behave alike: 42; 00; FF
    task automatic test_undefined();
        int cyc, wes;
        for (int k = 0; k < 3; k += 2) begin
            prep();
            img[k][0] = 8'h42; img[k][1] = 8'h00; img[k][2] = 8'hFF;
            run_prog(k, 200, cyc, wes);
            tests_run++;
            if (cyc !== ((k == 0) ? 15 : 21)) begin tests_failed++; $display("FAIL undef_cycles inst%0d: got %0d, required %0d", k, cyc, (k == 0) ? 15 : 21); end
        end
    endtask

    task automatic test_async_clear();
        bit found;
        prep();
        init_a[0] = 8'h07; init_b[0] = 8'h07;
        img[0][0] = 8'h04; img[0][1] = 8'h03; img[0][2] = 8'hFF;
        release_inst(0);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk); #1;
            if (z_latched[0] && enable_alu[0]) found = 1;
        end
        tests_run++;
        if (!found) begin tests_failed++; $display("FAIL alu_wait: got no X_ALU with z set, required one within 100"); end
        else begin
            clear_n[0] = 1'b0; #1;
            tests_run++;
            if (outs(0) !== O_INIT || z_latched[0] !== 1'b0) begin
                tests_failed++; $display("FAIL clr_alu: got %06h z%0b, required %06h z0", outs(0), z_latched[0], O_INIT);
            end
        end
        prep();
        init_a[0] = 8'h5A;
        img[0][0] = 8'h02; img[0][1] = 8'h30; img[0][2] = 8'hFF;
        sb_q.push_back(ev_t'{kind: 2'd1, addr: 8'h30, data: 8'h5A});
        release_inst(0);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk); #1;
            if (we_ram[0]) found = 1;
        end
        tests_run++;
        if (!found) begin tests_failed++; $display("FAIL st2_wait: got no X_ST2, required one within 100"); end
        else begin
            clear_n[0] = 1'b0; #1;
            tests_run++;
            if (we_ram[0] !== 1'b0 || outs(0) !== O_INIT) begin
                tests_failed++; $display("FAIL clr_st2: got we %0b outs %06h, required we 0 outs %06h", we_ram[0], outs(0), O_INIT);
            end
        end
        tests_run++;
        if (sb_q.size() != 0) begin tests_failed++; $display("FAIL clr_events: got %0d pending, required 0", sb_q.size()); end
    endtask

    initial begin
        prep();
        test_reset();
        test_program();
        test_carry_jump();
        test_zero_jumps();
        test_store();
        test_undefined();
        test_async_clear();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
